// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencer: operation codes,
// default latencies, FSM state encoding and small op-classification helpers.
package mdu_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_NONE  = 3'd0;
    localparam logic [OP_W-1:0] OP_MULT  = 3'd1;
    localparam logic [OP_W-1:0] OP_MULTU = 3'd2;
    localparam logic [OP_W-1:0] OP_DIV   = 3'd3;
    localparam logic [OP_W-1:0] OP_DIVU  = 3'd4;
    localparam logic [OP_W-1:0] OP_MTHI  = 3'd5;
    localparam logic [OP_W-1:0] OP_MTLO  = 3'd6;

    localparam int DEF_MUL_CYCLES = 5;
    localparam int DEF_DIV_CYCLES = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Ops that occupy the shared resource for a multi-cycle latency.
    function automatic logic is_md_op(input logic [OP_W-1:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_mul_op(input logic [OP_W-1:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

endpackage

// File: rtl/md_unit_ctrl_if.sv
// Issue/result bundle between the EX stage and the multiply/divide sequencer.
//   op_valid, op, a, b : issue side (driven by the pipeline, modport master)
//   start, busy        : handshake back to the hazard unit
//   hi, lo             : architectural HI/LO for the mfhi/mflo read path
interface md_unit_ctrl_if;
    import mdu_pkg::*;

    logic            op_valid;
    logic [OP_W-1:0] op;
    logic [31:0]     a;
    logic [31:0]     b;
    logic            start;
    logic            busy;
    logic [31:0]     hi;
    logic [31:0]     lo;

    modport master (
        output op_valid, op, a, b,
        input  start, busy, hi, lo
    );

    modport slave (
        input  op_valid, op, a, b,
        output start, busy, hi, lo
    );

endinterface

// File: rtl/mdu_arith.sv
// Purely combinational multiply/divide datapath.
//   op, a, b   : operation and operands
//   hi, lo     : current HI/LO, passed through when nothing is to be written
//   p_hi, p_lo : result that HI/LO will take when the operation commits
// A single unsigned divider serves both signednesses: signed divides work
// on magnitudes and fix up the signs afterwards, which also makes
// INT_MIN / -1 fall out naturally as quotient 0x80000000, remainder 0.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [OP_W-1:0] op,
    input  logic [31:0]     a,
    input  logic [31:0]     b,
    input  logic [31:0]     hi,
    input  logic [31:0]     lo,
    output logic [31:0]     p_hi,
    output logic [31:0]     p_lo
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic [31:0] quo;
    logic [31:0] rem;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        p_hi   = hi;
        p_lo   = lo;

        prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        prod_u = {32'd0, a} * {32'd0, b};

        a_neg  = (op == OP_DIV) && a[31];
        b_neg  = (op == OP_DIV) && b[31];
        a_mag  = a_neg ? (32'd0 - a) : a;
        b_mag  = b_neg ? (32'd0 - b) : b;
        div_q  = (b_mag != 32'd0) ? (a_mag / b_mag) : 32'd0;
        div_r  = (b_mag != 32'd0) ? (a_mag % b_mag) : 32'd0;
        // Quotient truncates toward zero; remainder follows the dividend.
        quo    = (a_neg ^ b_neg) ? (32'd0 - div_q) : div_q;
        rem    = a_neg ? (32'd0 - div_r) : div_r;

        case (op)
            OP_MULT:  {p_hi, p_lo} = prod_s;
            OP_MULTU: {p_hi, p_lo} = prod_u;
            OP_DIV, OP_DIVU: begin
                // Divide by zero leaves HI/LO untouched.
                if (b != 32'd0) begin
                    p_hi = rem;
                    p_lo = quo;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit_ctrl.sv
// Sequencer for the shared multiply/divide resource and HI/LO registers.
//   clk, reset_n : clock and asynchronous active-low reset
//   bus (slave)  : op_valid/op/a/b issue, start (combinational accept),
//                  busy (registered occupancy), hi/lo architectural values
// A mult/div is computed at issue into pending registers, the resource is
// then held for MUL_CYCLES or DIV_CYCLES, and the result is committed to
// HI/LO on the last busy cycle's edge. MTHI/MTLO write directly from IDLE.
module md_unit_ctrl
    import mdu_pkg::*;
#(
    parameter int MUL_CYCLES = DEF_MUL_CYCLES,
    parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
    input  logic           clk,
    input  logic           reset_n,
    md_unit_ctrl_if.slave  bus
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      p_hi_q, p_hi_d;
    logic [31:0]      p_lo_q, p_lo_d;
    logic [31:0]      arith_hi;
    logic [31:0]      arith_lo;
    logic             start_c;

    mdu_arith u_arith (
        .op   (bus.op),
        .a    (bus.a),
        .b    (bus.b),
        .hi   (hi_q),
        .lo   (lo_q),
        .p_hi (arith_hi),
        .p_lo (arith_lo)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            p_hi_q  <= '0;
            p_lo_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            p_hi_q  <= p_hi_d;
            p_lo_q  <= p_lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        p_hi_d  = p_hi_q;
        p_lo_d  = p_lo_q;
        start_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.op_valid) begin
                    if (is_md_op(bus.op)) begin
                        start_c = 1'b1;
                        p_hi_d  = arith_hi;
                        p_lo_d  = arith_lo;
                        cnt_d   = is_mul_op(bus.op) ? CNT_W'(MUL_CYCLES - 1)
                                                    : CNT_W'(DIV_CYCLES - 1);
                        state_d = ST_RUN;
                    end else if (bus.op == OP_MTHI) begin
                        hi_d = bus.a;
                    end else if (bus.op == OP_MTLO) begin
                        lo_d = bus.a;
                    end
                end
            end
            ST_RUN: begin
                // Any op presented here is ignored; only the countdown runs.
                if (cnt_q == '0) begin
                    hi_d    = p_hi_q;
                    lo_d    = p_lo_q;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The state register already reads IDLE during reset, so start needs
    // its own gate to stay low while reset_n is asserted.
    assign bus.start = start_c & reset_n;
    assign bus.busy  = (state_q == ST_RUN);
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Self-checking bench for md_unit_ctrl: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// timestamp-based behavioural model of the HI/LO unit.
module tb_md_unit_ctrl;
    import mdu_pkg::*;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic clk;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    md_unit_ctrl_if bus ();

    md_unit_ctrl #(
        .MUL_CYCLES (MUL_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of one md op, from plain 64-bit arithmetic.
    function automatic void ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] hi_in, input logic [31:0] lo_in,
                                       output logic [31:0] rh, output logic [31:0] rl);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = a;
        ub = b;
        rh = hi_in;
        rl = lo_in;
        case (op)
            OP_MULT: begin
                q  = sa * sb;
                rh = q[63:32];
                rl = q[31:0];
            end
            OP_MULTU: begin
                p  = ua * ub;
                rh = p[63:32];
                rl = p[31:0];
            end
            OP_DIV: if (b != 32'd0) begin
                q  = sa / sb;
                r  = sa % sb;
                rh = r[31:0];
                rl = q[31:0];
            end
            OP_DIVU: if (b != 32'd0) begin
                p  = ua / ub;
                rl = p[31:0];
                p  = ua % ub;
                rh = p[31:0];
            end
            default: ;
        endcase
    endfunction

    // Model state: architectural HI/LO, a pending result and the index of
    // the last cycle in which the resource is occupied.
    longint      cyc       = 0;
    longint      busy_last = -1;
    bit          m_pend    = 1'b0;
    logic [31:0] m_hi      = '0;
    logic [31:0] m_lo      = '0;
    logic [31:0] m_phi, m_plo;

    always @(negedge clk) begin
        bit exp_busy, exp_start, md;
        cyc++;
        if (!reset_n) begin
            m_hi      = '0;
            m_lo      = '0;
            m_pend    = 1'b0;
            busy_last = -1;
        end else if (m_pend && cyc > busy_last) begin
            m_hi   = m_phi;
            m_lo   = m_plo;
            m_pend = 1'b0;
        end
        md        = (bus.op == OP_MULT) || (bus.op == OP_MULTU) || (bus.op == OP_DIV) || (bus.op == OP_DIVU);
        exp_busy  = reset_n && (cyc <= busy_last);
        exp_start = reset_n && bus.op_valid && md && !exp_busy;

        check("cyc_start", {31'd0, bus.start}, {31'd0, exp_start});
        check("cyc_busy",  {31'd0, bus.busy},  {31'd0, exp_busy});
        check("cyc_hi", bus.hi, m_hi);
        check("cyc_lo", bus.lo, m_lo);

        if (exp_start) begin
            ref_result(bus.op, bus.a, bus.b, m_hi, m_lo, m_phi, m_plo);
            m_pend    = 1'b1;
            busy_last = cyc + (((bus.op == OP_MULT) || (bus.op == OP_MULTU)) ? MUL_N : DIV_N);
        end else if (reset_n && !exp_busy && bus.op_valid) begin
            if (bus.op == OP_MTHI) m_hi = bus.a;
            if (bus.op == OP_MTLO) m_lo = bus.a;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.op_valid = 1'b1;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
    endtask

    task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int n, input logic [31:0] eh, input logic [31:0] el);
        drive(op, a, b);
        #1;
        check({tag, "_start"}, {31'd0, bus.start}, 32'd1);
        step();
        bus.op_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            check({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
            step();
        end
        check({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
        check({tag, "_hi"}, bus.hi, eh);
        check({tag, "_lo"}, bus.lo, el);
    endtask

    task automatic run_mt(input string tag, input logic [2:0] op, input logic [31:0] a);
        drive(op, a, 32'd0);
        #1;
        check({tag, "_start"}, {31'd0, bus.start}, 32'd0);
        step();
        bus.op_valid = 1'b0;
        check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        check({tag, "_val"}, (op == OP_MTHI) ? bus.hi : bus.lo, a);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'd0;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset with an md op already presented: start must stay low.
        reset_n = 1'b0;
        drive(OP_MULT, 32'd1, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check("rst_start", {31'd0, bus.start}, 32'd0);
        check("rst_busy",  {31'd0, bus.busy},  32'd0);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        bus.op_valid = 1'b0;
        #2 reset_n = 1'b1;
        step();

        run_md("mult",   OP_MULT,  32'hFFFF_FFFE, 32'd3,          MUL_N, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_md("multu",  OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  MUL_N, 32'hFFFF_FFFE, 32'h0000_0001);
        run_md("div",    OP_DIV,   32'hFFFF_FFF9, 32'd2,          DIV_N, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md("divmin", OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF,  DIV_N, 32'h0000_0000, 32'h8000_0000);

        run_mt("mthi", OP_MTHI, 32'h0000_1234);
        run_mt("mtlo", OP_MTLO, 32'h0000_5678);
        run_md("div0", OP_DIVU, 32'd7, 32'd0, DIV_N, 32'h0000_1234, 32'h0000_5678);

        // Ops presented while busy are ignored.
        drive(OP_MULTU, 32'd3, 32'd5);
        #1;
        check("ib_start", {31'd0, bus.start}, 32'd1);
        step();
        bus.op_valid = 1'b0;
        step();
        drive(OP_MTLO, 32'h0000_DEAD, 32'd0);
        #1;
        check("ib_mtlo_start", {31'd0, bus.start}, 32'd0);
        step();
        drive(OP_DIV, 32'd9, 32'd2);
        #1;
        check("ib_div_start", {31'd0, bus.start}, 32'd0);
        step();
        bus.op_valid = 1'b0;
        check("ib_busy4", {31'd0, bus.busy}, 32'd1);
        step();
        check("ib_busy5", {31'd0, bus.busy}, 32'd1);
        step();
        check("ib_idle", {31'd0, bus.busy}, 32'd0);
        check("ib_lo", bus.lo, 32'd15);
        check("ib_hi", bus.hi, 32'd0);
        run_md("b2b", OP_MULT, 32'd7, 32'hFFFF_FFFD, MUL_N, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

        // Reset between edges in the middle of a divide.
        drive(OP_DIV, 32'd100, 32'd7);
        step();
        bus.op_valid = 1'b0;
        repeat (3) step();
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("mid_rst_hi", bus.hi, 32'd0);
        check("mid_rst_lo", bus.lo, 32'd0);
        step();
        step();
        #2 reset_n = 1'b1;
        step();
        run_mt("post_rst_mthi", OP_MTHI, 32'h0000_00A5);

        // Random traffic, including ops presented while busy.
        for (int i = 0; i < 400; i++) begin
            bus.op_valid = ($urandom_range(0, 9) < 6);
            bus.op       = 3'($urandom_range(0, 7));
            bus.a        = pick_operand();
            bus.b        = ($urandom_range(0, 9) == 0) ? 32'd0 : pick_operand();
            step();
        end
        bus.op_valid = 1'b0;
        repeat (DIV_N + 2) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/md_unit_ctrl.md
# md_unit_ctrl

Sequencer for the shared multiply/divide resource and its HI/LO registers in the P6 pipeline's EX stage. It accepts one mult/multu/div/divu/mthi/mtlo operation per issue and holds the resource for a fixed latency. It generates the `start`/`busy` pair that the hazard unit uses to stall any D-stage md/HI-LO instruction, and presents HI/LO to the mfhi/mflo read path.

## Interface
Parameters:
- MUL_CYCLES, 5, busy duration for mult/multu (>=1)
- DIV_CYCLES, 10, busy duration for div/divu (>=1)

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- op_valid  in  1  EX-stage instruction is an md/HI-LO-write op
- op  in  3  operation code (mdu_pkg encoding)
- a  in  32  forwarded GPR[rs]
- b  in  32  forwarded GPR[rt]
- start  out  1  combinational; issue accepted this cycle
- busy  out  1  registered; resource occupied
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- Op encoding: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6; codes 7 and NONE are no-ops.
- States: IDLE, RUN. The state is reset to IDLE.
- start = op_valid & op∈{MULT,MULTU,DIV,DIVU} & state==IDLE.
- IDLE, start:
  - Compute the result into pending registers p_hi/p_lo.
  - Load the counter with MUL_CYCLES-1 or DIV_CYCLES-1.
  - Go to RUN.
- RUN:
  - Decrement the counter each cycle.
  - When the counter is 0, commit hi<=p_hi and lo<=p_lo, then go to IDLE.
- busy = (state==RUN).
- MTHI/MTLO in IDLE: hi<=a or lo<=a at the edge. There is no busy and no start.
- Any op presented in RUN is ignored (no state change). The hazard unit prevents this, but the block must not corrupt HI/LO.
- MULT: {hi,lo} = signed a × signed b, 64-bit.
- MULTU: {hi,lo} = unsigned a × unsigned b, 64-bit.
- DIV (signed):
  - lo = quotient, truncated toward zero.
  - hi = remainder, which takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- DIVU: unsigned quotient to lo, unsigned remainder to hi.
- Divide by zero (b==0), either signedness:
  - Full latency still runs.
  - At commit, hi and lo keep their pre-issue values.
- Reset: state=IDLE, counter=0, busy=0, hi=0, lo=0, p_hi=p_lo=0. start is 0 while reset_n is low.
- Reset asserted mid-RUN aborts the operation. Nothing is committed, and busy falls asynchronously.

## Timing
- Issue cycle T: start=1 combinationally, busy=0.
- busy=1 in cycles T+1 … T+N, where N = MUL_CYCLES or DIV_CYCLES.
- New hi/lo are visible from cycle T+N+1, the same cycle busy first reads 0.
- Back-to-back issue: an md op presented in cycle T+N+1 is accepted (start=1).
- MTHI/MTLO take 1 cycle: the new value is visible the cycle after issue.
- An mfhi/mflo in cycle T+N+1 reads the committed result.
- During busy, hi/lo hold their old values. The hazard unit's stall prevents reads in this window.
- Async reset takes effect without a clock edge. The first legal issue is the first edge after reset_n rises.

## Structure
- Package mdu_pkg holds:
  - op code localparams,
  - default latency constants,
  - state encoding.
- Sub-module mdu_arith: purely combinational. Inputs op, a, b, hi, lo; outputs p_hi and p_lo, including the divide-by-zero hold and INT_MIN/-1 rules.
- md_unit_ctrl contains only the FSM, the counter, and the HI/LO/pending registers.

## Test plan
- MULT a=0xFFFFFFFE (-2), b=3 issued at T:
  - start=1 at T, busy high T+1…T+5.
  - At T+6: hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF: after 5 busy cycles, hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=-7 (0xFFFFFFF9), b=2:
  - busy exactly 10 cycles.
  - Then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Then DIV 0x80000000/0xFFFFFFFF gives lo=0x80000000, hi=0.
- Divide by zero: MTHI 0x1234, MTLO 0x5678, then DIVU b=0. After 10 busy cycles, hi=0x1234, lo=0x5678 are unchanged.
- Issue while busy:
  - MULTU issued, then at T+2 present MTLO a=0xDEAD and DIV. Both are ignored: start=0, busy still falls at T+6, lo = the product.
  - A MULT presented at T+6 gets start=1.
- Reset mid-op:
  - DIV issued, then reset_n=0 at T+4 (between edges). busy goes to 0 immediately; hi=lo=0.
  - After release, MTHI a=0xA5 gives hi=0xA5 next cycle.
